// File: rtl/mem_pkg.sv
// Shared types and helpers for the paged BRAM write stage.
// The optional drop counter is enabled with MEM_PAGE_WRITER_DROP_CNT_EN.
package mem_pkg;

    localparam int MEM_PAGE_BITS = 3;
    localparam int MEM_ENT_BITS  = 7;
    localparam int NPAGE         = 2 ** MEM_PAGE_BITS;
    localparam int PAGE_DEPTH    = 2 ** MEM_ENT_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

    function automatic logic [NPAGE-1:0] onehot_page(
        input logic [MEM_PAGE_BITS-1:0] page
    );
        return NPAGE'(1) << page;
    endfunction

endpackage

// File: rtl/mem_page_writer_counter.sv
// Per-event entry counter: saturates at the page depth, clear wins over inc.
module page_entry_counter #(
    parameter int ENT_BITS   = 7,
    parameter int NENT_WIDTH = 8
) (
    input  logic                  clka,
    input  logic                  rstb,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [ENT_BITS-1:0]   idx_o,
    output logic                  full_o,
    output logic [NENT_WIDTH-1:0] next_o
);

    localparam logic [NENT_WIDTH-1:0] DEPTH = NENT_WIDTH'(2 ** ENT_BITS);

    logic [NENT_WIDTH-1:0] cnt_q;
    logic [NENT_WIDTH-1:0] cnt_d;

    assign full_o = (cnt_q == DEPTH);
    assign next_o = cnt_q + NENT_WIDTH'(1);
    assign idx_o  = cnt_q[ENT_BITS-1:0];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !full_o)
            cnt_d = next_o;
    end

    always_ff @(posedge clka) begin
        if (rstb)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_page_writer.sv
// Write stage for the paged BRAM: registered word writes plus per-page nent updates.
// Define MEM_PAGE_WRITER_DROP_CNT_EN to add the drop_cnt_o counter port.
module mem_page_writer
    import mem_pkg::*;
#(
    parameter int RAM_WIDTH  = 18,
    parameter int PAGE_BITS  = MEM_PAGE_BITS,
    parameter int ENT_BITS   = MEM_ENT_BITS,
    parameter int NENT_WIDTH = 8
) (
    input  logic                          clka,
    input  logic                          rstb,
    input  logic                          start_i,
    input  logic [PAGE_BITS-1:0]          bx_i,
    input  logic                          din_valid_i,
    input  logic [RAM_WIDTH-1:0]          din_i,
    output logic                          wea_o,
    output logic [PAGE_BITS+ENT_BITS-1:0] addra_o,
    output logic [RAM_WIDTH-1:0]          dina_o,
    output logic [NENT_WIDTH-1:0]         nent_data_o,
    output logic [2**PAGE_BITS-1:0]       nent_we_o,
    output logic                          busy_o,
    output logic                          overflow_o
`ifdef MEM_PAGE_WRITER_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_cnt_o
`endif
);

    localparam int NPG = 2 ** PAGE_BITS;

    wr_state_t                     state_q;
    logic [PAGE_BITS-1:0]          page_q;
    logic                          clr_pend_q;
    logic                          wea_q;
    logic [PAGE_BITS+ENT_BITS-1:0] addra_q;
    logic [RAM_WIDTH-1:0]          dina_q;
    logic [NENT_WIDTH-1:0]         nent_data_q;
    logic [NPG-1:0]                nent_we_q;
    logic                          busy_q;
    logic                          overflow_q;

    logic                  cnt_inc;
    logic [ENT_BITS-1:0]   cnt_idx;
    logic                  cnt_full;
    logic [NENT_WIDTH-1:0] cnt_next;

    assign cnt_inc = (state_q == WRITE) && din_valid_i;

    page_entry_counter #(
        .ENT_BITS  (ENT_BITS),
        .NENT_WIDTH(NENT_WIDTH)
    ) u_cnt (
        .clka  (clka),
        .rstb  (rstb),
        .clr_i (start_i),
        .inc_i (cnt_inc),
        .idx_o (cnt_idx),
        .full_o(cnt_full),
        .next_o(cnt_next)
    );

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q     <= IDLE;
            page_q      <= '0;
            clr_pend_q  <= 1'b0;
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dina_q      <= '0;
            nent_data_q <= '0;
            nent_we_q   <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wea_q     <= 1'b0;
            nent_we_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= WRITE;
                        busy_q      <= 1'b1;
                        page_q      <= bx_i;
                        overflow_q  <= 1'b0;
                        clr_pend_q  <= 1'b0;
                        nent_we_q   <= onehot_page(bx_i);
                        nent_data_q <= '0;
                    end
                end
                WRITE: begin
                    if (din_valid_i && !cnt_full) begin
                        wea_q       <= 1'b1;
                        addra_q     <= {page_q, cnt_idx};
                        dina_q      <= din_i;
                        nent_we_q   <= onehot_page(page_q);
                        nent_data_q <= cnt_next;
                    end else if (din_valid_i) begin
                        overflow_q <= 1'b1;
                    end
                    if (start_i) begin
                        page_q     <= bx_i;
                        overflow_q <= 1'b0;
                        // nent bus is taken by the old event's word: defer the clear
                        if (din_valid_i) begin
                            clr_pend_q <= 1'b1;
                        end else begin
                            clr_pend_q  <= 1'b0;
                            nent_we_q   <= onehot_page(bx_i);
                            nent_data_q <= '0;
                        end
                    end else if (clr_pend_q) begin
                        clr_pend_q <= 1'b0;
                        // a word now writes nent=1, which subsumes the clear
                        if (!din_valid_i) begin
                            nent_we_q   <= onehot_page(page_q);
                            nent_data_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wea_o       = wea_q;
    assign addra_o     = addra_q;
    assign dina_o      = dina_q;
    assign nent_data_o = nent_data_q;
    assign nent_we_o   = nent_we_q;
    assign busy_o      = busy_q;
    assign overflow_o  = overflow_q;

`ifdef MEM_PAGE_WRITER_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clka) begin
        if (rstb)
            drop_q <= '0;
        else if (start_i)
            drop_q <= '0;
        else if (cnt_inc && cnt_full && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
    end

    assign drop_cnt_o = drop_q;
`endif

endmodule

// File: tb/tb_mem_page_writer.sv
// Directed vector bench for mem_page_writer.
module tb_mem_page_writer;

    logic        clka = 1'b0;
    logic        rstb;
    logic        start_i;
    logic [2:0]  bx_i;
    logic        din_valid_i;
    logic [17:0] din_i;
    logic        wea_o;
    logic [9:0]  addra_o;
    logic [17:0] dina_o;
    logic [7:0]  nent_data_o;
    logic [7:0]  nent_we_o;
    logic        busy_o;
    logic        overflow_o;
`ifdef MEM_PAGE_WRITER_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clka = ~clka;

    mem_page_writer dut (
        .clka       (clka),
        .rstb       (rstb),
        .start_i    (start_i),
        .bx_i       (bx_i),
        .din_valid_i(din_valid_i),
        .din_i      (din_i),
        .wea_o      (wea_o),
        .addra_o    (addra_o),
        .dina_o     (dina_o),
        .nent_data_o(nent_data_o),
        .nent_we_o  (nent_we_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
`ifdef MEM_PAGE_WRITER_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    typedef struct {
        logic        st;
        logic [2:0]  bx;
        logic        v;
        logic [17:0] d;
        logic        wea;
        int          addr;
        logic [17:0] dina;
        logic [7:0]  nwe;
        logic [7:0]  nd;
        logic        busy;
        logic        ovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic st, input logic [2:0] bx, input logic v,
        input logic [17:0] d, input logic wea, input int addr,
        input logic [17:0] dina, input logic [7:0] nwe,
        input logic [7:0] nd, input logic busy, input logic ovf
    );
        vec_t r;
        r.st = st; r.bx = bx; r.v = v; r.d = d;
        r.wea = wea; r.addr = addr; r.dina = dina;
        r.nwe = nwe; r.nd = nd; r.busy = busy; r.ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] bx,
                         input logic v, input logic [17:0] d);
        start_i = st; bx_i = bx; din_valid_i = v; din_i = d;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wea"}, int'(wea_o), 0);
        chk({tag, ".addr"}, int'(addra_o), 0);
        chk({tag, ".dina"}, int'(dina_o), 0);
        chk({tag, ".nwe"}, int'(nent_we_o), 0);
        chk({tag, ".nd"}, int'(nent_data_o), 0);
        chk({tag, ".busy"}, int'(busy_o), 0);
        chk({tag, ".ovf"}, int'(overflow_o), 0);
    endtask

    initial begin
        int wr_cnt;
        int last_addr;
        int last_nd;
        string nm;

        rstb = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 18'h0);
        step();
        step();
        chk_zero("reset");
        rstb = 1'b0;

        // IDLE ignores data, start with a simultaneous word drops that word
        vt.push_back(mk(0, 0, 1, 18'h111, 0, 0, 18'h0, 8'h00, 0, 0, 0));
        vt.push_back(mk(1, 3, 1, 18'h222, 0, 0, 18'h0, 8'h08, 0, 1, 0));
        for (int k = 0; k < 5; k++)
            vt.push_back(mk(0, 0, 1, 18'(16 + k), 1, 384 + k, 18'(16 + k),
                            8'h08, 8'(k + 1), 1, 0));
        vt.push_back(mk(0, 0, 0, 18'h0, 0, 388, 18'h14, 8'h00, 5, 1, 0));
        // page 1 to count 4, then start bx=6 together with a word
        vt.push_back(mk(1, 1, 0, 18'h0, 0, 388, 18'h14, 8'h02, 0, 1, 0));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(0, 0, 1, 18'(32 + k), 1, 128 + k, 18'(32 + k),
                            8'h02, 8'(k + 1), 1, 0));
        vt.push_back(mk(1, 6, 1, 18'h3AB, 1, 132, 18'h3AB, 8'h02, 5, 1, 0));
        vt.push_back(mk(0, 0, 0, 18'h0, 0, 132, 18'h3AB, 8'h40, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 18'h44, 1, 768, 18'h44, 8'h40, 1, 1, 0));
        // start+word, then a word straight away: clear merged into nent=1
        vt.push_back(mk(1, 4, 1, 18'h55, 1, 769, 18'h55, 8'h40, 2, 1, 0));
        vt.push_back(mk(0, 0, 1, 18'h56, 1, 512, 18'h56, 8'h10, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 18'h0, 0, 512, 18'h56, 8'h00, 1, 1, 0));
        // same bx again restarts page 4 from entry 0
        vt.push_back(mk(1, 4, 0, 18'h0, 0, 512, 18'h56, 8'h10, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 18'h57, 1, 512, 18'h57, 8'h10, 1, 1, 0));
        vt.push_back(mk(0, 0, 1, 18'h58, 1, 513, 18'h58, 8'h10, 2, 1, 0));

        foreach (vt[i]) begin
            drive(vt[i].st, vt[i].bx, vt[i].v, vt[i].d);
            step();
            nm = $sformatf("v%0d", i);
            chk({nm, ".wea"}, int'(wea_o), int'(vt[i].wea));
            chk({nm, ".addr"}, int'(addra_o), vt[i].addr);
            chk({nm, ".dina"}, int'(dina_o), int'(vt[i].dina));
            chk({nm, ".nwe"}, int'(nent_we_o), int'(vt[i].nwe));
            chk({nm, ".nd"}, int'(nent_data_o), int'(vt[i].nd));
            chk({nm, ".busy"}, int'(busy_o), int'(vt[i].busy));
            chk({nm, ".ovf"}, int'(overflow_o), int'(vt[i].ovf));
        end

        // fill page 2 with 130 words
        drive(1'b1, 3'd2, 1'b0, 18'h0);
        step();
        chk("fill.clear_nwe", int'(nent_we_o), 8'h04);
        wr_cnt = 0;
        last_addr = -1;
        last_nd = -1;
        for (int i = 0; i < 130; i++) begin
            drive(1'b0, 3'd0, 1'b1, 18'(1000 + i));
            step();
            if (wea_o) begin
                wr_cnt++;
                last_addr = int'(addra_o);
            end
            if (nent_we_o != 8'h00)
                last_nd = int'(nent_data_o);
            if (i == 127)
                chk("fill.ovf_at_128", int'(overflow_o), 0);
            if (i == 128) begin
                chk("fill.drop_wea", int'(wea_o), 0);
                chk("fill.drop_nwe", int'(nent_we_o), 0);
                chk("fill.ovf_at_129", int'(overflow_o), 1);
            end
        end
        chk("fill.writes", wr_cnt, 128);
        chk("fill.last_addr", last_addr, 2 * 128 + 127);
        chk("fill.last_nent", last_nd, 128);
        chk("fill.ovf_sticky", int'(overflow_o), 1);
`ifdef MEM_PAGE_WRITER_DROP_CNT_EN
        chk("fill.drop_cnt", int'(drop_cnt_o), 2);
`endif
        drive(1'b1, 3'd5, 1'b0, 18'h0);
        step();
        chk("restart.ovf_clr", int'(overflow_o), 0);
        chk("restart.nwe", int'(nent_we_o), 8'h20);

        // reset mid-event after 10 words
        drive(1'b1, 3'd7, 1'b0, 18'h0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 3'd0, 1'b1, 18'(200 + i));
            step();
        end
        chk("mid.addr_before", int'(addra_o), 7 * 128 + 9);
        rstb = 1'b1;
        drive(1'b1, 3'd1, 1'b1, 18'h3FF);
        step();
        chk_zero("midrst");
        rstb = 1'b0;
        drive(1'b0, 3'd0, 1'b1, 18'h77);
        step();
        chk("postrst.idle_wea", int'(wea_o), 0);
        chk("postrst.idle_busy", int'(busy_o), 0);
        drive(1'b1, 3'd0, 1'b0, 18'h0);
        step();
        chk("postrst.clr_nwe", int'(nent_we_o), 8'h01);
        drive(1'b0, 3'd0, 1'b1, 18'h99);
        step();
        chk("postrst.wea", int'(wea_o), 1);
        chk("postrst.addr", int'(addra_o), 0);
        chk("postrst.dina", int'(dina_o), 18'h99);
        chk("postrst.nd", int'(nent_data_o), 1);
        drive(1'b0, 3'd0, 1'b0, 18'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
